cnn_job_scheduler: RTL and testbench

//  Shares the single CIFAR-10 CNN accelerator engine between N_REQ requesters (RISC-V core, DMA,

---
 rtl/cnn_job_scheduler.sv | 176 +++++++++++++++++
 tb/tb_cnn_job_scheduler.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/cnn_job_scheduler.sv
// cnn_job_scheduler: shares one CNN inference engine between N_REQ requesters.
// Round-robin grant, one job in flight, watchdog abort, result returned to the owner.
// All outputs are registered; the FSM runs IDLE -> START -> BUSY -> RESP -> IDLE.
module cnn_job_scheduler #(
    parameter int              N_REQ       = 2,
    parameter int              TO_W        = 24,
    parameter logic [TO_W-1:0] TIMEOUT_CYC = 24'hF00000,
    parameter int              NUM_CLASSES = 10
) (
    input  logic             clk_i,
    input  logic             resetn_i,
    input  logic [N_REQ-1:0] req_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [N_REQ-1:0] rsp_valid_o,
    output logic [3:0]       rsp_class_o,
    output logic             rsp_timeout_o,
    output logic             rsp_err_o,
    output logic             eng_start_o,
    output logic             eng_abort_o,
    input  logic             eng_done_i,
    input  logic [3:0]       eng_class_i,
    output logic             busy_o,
    output logic [2:0]       owner_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_BUSY  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // Last watchdog value before a job is declared timed out.
    localparam logic [TO_W-1:0] TO_LAST = TIMEOUT_CYC - TO_W'(1);

    state_t            state_q, state_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [3:0]        rsp_class_q, rsp_class_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic              rsp_err_q, rsp_err_d;
    logic              eng_start_q, eng_start_d;
    logic              eng_abort_q, eng_abort_d;
    logic              busy_q, busy_d;
    logic [2:0]        owner_q, owner_d;
    logic [2:0]        rr_q, rr_d;
    logic [TO_W-1:0]   wd_q, wd_d;
    logic              first_q, first_d;   // first BUSY cycle: a stale done level is ignored

    logic [2:0]        sel;
    logic              found;

    function automatic logic [N_REQ-1:0] onehot(input logic [2:0] idx);
        logic [N_REQ-1:0] v;
        for (int i = 0; i < N_REQ; i++) begin
            v[i] = (idx == 3'(i));
        end
        return v;
    endfunction

    // Round-robin pick: first requester set, searching upward from rr+1 with wrap.
    always_comb begin
        sel   = rr_q;
        found = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            if (!found && req_i[(int'(rr_q) + i) % N_REQ]) begin
                found = 1'b1;
                sel   = 3'((int'(rr_q) + i) % N_REQ);
            end
        end
    end

    // Next-state and registered-output logic; pulses default low, results hold.
    always_comb begin
        state_d       = state_q;
        grant_d       = '0;
        rsp_valid_d   = '0;
        eng_start_d   = 1'b0;
        eng_abort_d   = 1'b0;
        rsp_class_d   = rsp_class_q;
        rsp_timeout_d = rsp_timeout_q;
        rsp_err_d     = rsp_err_q;
        busy_d        = busy_q;
        owner_d       = owner_q;
        rr_d          = rr_q;
        wd_d          = wd_q;
        first_d       = first_q;
        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_d = onehot(sel);
                    owner_d = sel;
                    rr_d    = sel;
                    busy_d  = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                eng_start_d = 1'b1;
                wd_d        = '0;
                first_d     = 1'b1;
                state_d     = S_BUSY;
            end
            S_BUSY: begin
                if (first_q) begin
                    first_d = 1'b0;
                end else begin
                    wd_d = wd_q + TO_W'(1);
                    if (eng_done_i) begin
                        rsp_class_d   = eng_class_i;
                        rsp_err_d     = (int'(eng_class_i) >= NUM_CLASSES);
                        rsp_timeout_d = 1'b0;
                        rsp_valid_d   = onehot(owner_q);
                        state_d       = S_RESP;
                    end else if (wd_q == TO_LAST) begin
                        rsp_class_d   = 4'hF;
                        rsp_err_d     = 1'b0;
                        rsp_timeout_d = 1'b1;
                        eng_abort_d   = 1'b1;
                        rsp_valid_d   = onehot(owner_q);
                        state_d       = S_RESP;
                    end
                end
            end
            S_RESP: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q       <= S_IDLE;
            grant_q       <= '0;
            rsp_valid_q   <= '0;
            rsp_class_q   <= 4'd0;
            rsp_timeout_q <= 1'b0;
            rsp_err_q     <= 1'b0;
            eng_start_q   <= 1'b0;
            eng_abort_q   <= 1'b0;
            busy_q        <= 1'b0;
            owner_q       <= 3'd0;
            rr_q          <= 3'(N_REQ - 1);
            wd_q          <= '0;
            first_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_class_q   <= rsp_class_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_err_q     <= rsp_err_d;
            eng_start_q   <= eng_start_d;
            eng_abort_q   <= eng_abort_d;
            busy_q        <= busy_d;
            owner_q       <= owner_d;
            rr_q          <= rr_d;
            wd_q          <= wd_d;
            first_q       <= first_d;
        end
    end

    assign grant_o       = grant_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_class_o   = rsp_class_q;
    assign rsp_timeout_o = rsp_timeout_q;
    assign rsp_err_o     = rsp_err_q;
    assign eng_start_o   = eng_start_q;
    assign eng_abort_o   = eng_abort_q;
    assign busy_o        = busy_q;
    assign owner_o       = owner_q;

endmodule

// File: tb/tb_cnn_job_scheduler.sv
// Directed bench for cnn_job_scheduler (N_REQ=2, TIMEOUT_CYC=50).
module tb_cnn_job_scheduler;

    logic       clk = 1'b0;
    logic       resetn;
    logic [1:0] req;
    logic [1:0] grant;
    logic [1:0] rsp_valid;
    logic [3:0] rsp_class;
    logic       rsp_timeout, rsp_err, eng_start, eng_abort;
    logic       eng_done;
    logic [3:0] eng_class;
    logic       busy;
    logic [2:0] owner;

    int checks   = 0;
    int failures = 0;
    int n;
    int bad;

    cnn_job_scheduler #(
        .N_REQ      (2),
        .TO_W       (24),
        .TIMEOUT_CYC(24'd50),
        .NUM_CLASSES(10)
    ) dut (
        .clk_i        (clk),
        .resetn_i     (resetn),
        .req_i        (req),
        .grant_o      (grant),
        .rsp_valid_o  (rsp_valid),
        .rsp_class_o  (rsp_class),
        .rsp_timeout_o(rsp_timeout),
        .rsp_err_o    (rsp_err),
        .eng_start_o  (eng_start),
        .eng_abort_o  (eng_abort),
        .eng_done_i   (eng_done),
        .eng_class_i  (eng_class),
        .busy_o       (busy),
        .owner_o      (owner)
    );

    always #5 clk = ~clk;

    // Advance one clock; sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // All outputs at their reset values (packed into one word).
    task automatic chk_reset(input string tag);
        chk(tag, {grant, rsp_valid, rsp_class, rsp_timeout, rsp_err, eng_start, eng_abort, busy, owner},
            32'h0);
    endtask

    initial begin
        resetn = 1'b0; req = 2'b00; eng_done = 1'b0; eng_class = 4'd0;
        tick(); tick();
        chk_reset("reset_state");
        resetn = 1'b1;

        // T1 single job, requester 0, class 3 after 40 engine cycles
        req = 2'b01;
        tick();
        chk("t1_grant", grant, 2'b01);
        chk("t1_busy_owner", {busy, owner}, {1'b1, 3'd0});
        chk("t1_no_start_yet", eng_start, 1'b0);
        req = 2'b00;
        tick();
        chk("t1_start", {eng_start, grant}, {1'b1, 2'b00});
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (eng_start !== 1'b0 || rsp_valid !== 2'b00 || busy !== 1'b1) bad++;
        end
        chk("t1_wait_quiet", bad, 0);
        eng_done = 1'b1; eng_class = 4'd3;
        tick();
        chk("t1_rsp", {rsp_valid, rsp_class, rsp_timeout, rsp_err, busy}, {2'b01, 4'd3, 1'b0, 1'b0, 1'b1});
        eng_done = 1'b0;
        tick();
        chk("t1_rsp_pulse_end", {rsp_valid, busy}, {2'b00, 1'b0});
        chk("t1_hold_class", rsp_class, 4'd3);

        // Reset so the round-robin pointer starts at N_REQ-1
        resetn = 1'b0;
        tick();
        chk_reset("reset_again");
        resetn = 1'b1;

        // T2 round robin with both requests held: grants 0,1,0,1
        req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("t2_grant%0d", k), grant, (k % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            chk($sformatf("t2_start%0d", k), eng_start, 1'b1);
            tick();
            eng_done = 1'b1; eng_class = 4'(k + 1);
            tick();
            chk($sformatf("t2_rsp%0d", k), {rsp_valid, rsp_class, owner},
                {((k % 2 == 0) ? 2'b01 : 2'b10), 4'(k + 1), 3'(k % 2)});
            eng_done = 1'b0;
            if (k == 3) req = 2'b00;
            tick();
            chk($sformatf("t2_idle%0d", k), {busy, grant}, {1'b0, 2'b00});
        end

        // T3 watchdog timeout, requester 1 (rr now 1, only req[1] set)
        req = 2'b10;
        tick();
        chk("t3_grant", grant, 2'b10);
        req = 2'b00;
        tick();
        chk("t3_start", eng_start, 1'b1);
        n = 0;
        while (rsp_valid === 2'b00 && n < 200) begin
            tick();
            n++;
        end
        chk("t3_latency", n, 51);
        chk("t3_rsp", {rsp_valid, rsp_class, rsp_timeout, rsp_err, eng_abort},
            {2'b10, 4'hF, 1'b1, 1'b0, 1'b1});
        tick();
        chk("t3_abort_pulse", {eng_abort, rsp_valid}, {1'b0, 2'b00});

        // T4 next request served normally, engine reports out-of-range class 12
        req = 2'b01;
        tick();
        chk("t4_grant", grant, 2'b01);
        req = 2'b00;
        tick();
        tick();
        eng_done = 1'b1; eng_class = 4'd12;
        tick();
        chk("t4_rsp", {rsp_valid, rsp_class, rsp_timeout, rsp_err}, {2'b01, 4'd12, 1'b0, 1'b1});
        tick();

        // T5 stale done level into a new job, then done coincident with timeout
        req = 2'b10;
        tick();
        chk("t5_grant", grant, 2'b10);
        req = 2'b00;
        tick();
        chk("t5_start", eng_start, 1'b1);
        tick();
        chk("t5_stale_ignored", {rsp_valid, busy}, {2'b00, 1'b1});
        eng_done = 1'b0;
        bad = 0;
        for (int i = 0; i < 49; i++) begin
            tick();
            if (rsp_valid !== 2'b00) bad++;
        end
        chk("t5_no_early_rsp", bad, 0);
        eng_done = 1'b1; eng_class = 4'd5;
        tick();
        chk("t5_done_wins", {rsp_valid, rsp_class, rsp_timeout, rsp_err, eng_abort},
            {2'b10, 4'd5, 1'b0, 1'b0, 1'b0});
        eng_done = 1'b0;
        tick();

        // T6 reset in the middle of BUSY drops the job silently
        req = 2'b01;
        tick();
        chk("t6_grant", grant, 2'b01);
        req = 2'b00;
        for (int i = 0; i < 6; i++) tick();
        resetn = 1'b0;
        tick();
        chk_reset("t6_reset_outputs");
        resetn = 1'b1;
        eng_done = 1'b1; eng_class = 4'd2;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (rsp_valid !== 2'b00 || busy !== 1'b0 || eng_start !== 1'b0) bad++;
        end
        chk("t6_no_rsp_after_reset", bad, 0);
        eng_done = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
